// File: rtl/toggle_cover_scheduler_if.sv
// Hit-strobe input and back-pressured report port of toggle_cover_scheduler.
// The slave side is the scheduler; the master side drives hits and consumes reports.
interface toggle_cover_scheduler_if #(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned IDX_W = 64;

    logic [WIDTH-1:0] valid;
    logic             enable;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;

    modport master (
        output valid,
        output enable,
        output out_ready,
        input  out_valid,
        input  out_index
    );

    modport slave (
        input  valid,
        input  enable,
        input  out_ready,
        output out_valid,
        output out_index
    );
endinterface

// File: rtl/toggle_cover_scheduler.sv
// Buffers WIDTH toggle-coverage hit strobes in a pending bitmap and drains them
// round-robin as absolute cover indices, one per handshake, with flush and report-once support.
module toggle_cover_scheduler #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned COVER_TOTAL = 8940,
    parameter int unsigned COVER_INDEX = 0,
    parameter bit          ONCE        = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    toggle_cover_scheduler_if.slave  bus,
    input  logic                     clear_i,
    input  logic                     flush_req_i,
    output logic                     flush_done_o,
    output logic                     idle_o,
    output logic [31:0]              hit_count_o,
    output logic [31:0]              coalesce_count_o
);
    localparam int unsigned PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned POP_W = $clog2(WIDTH + 1);
    localparam int unsigned CNT_W = 32;
    localparam int unsigned IDX_W = 64;
    localparam logic [PTR_W:0]   WIDTH_P = (PTR_W + 1)'(WIDTH);
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(WIDTH - 1);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] reported_q, reported_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_index_q, out_index_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic [CNT_W-1:0] coal_count_q, coal_count_d;
    logic             flush_done_q, flush_done_d;
    logic             idle_q, idle_d;

    logic [WIDTH-1:0] rot;
    logic             found;
    logic [PTR_W-1:0] off;
    logic [PTR_W:0]   sel_sum;
    logic [PTR_W-1:0] sel;
    logic             can_load, do_load, handshake, accept;
    logic [WIDTH-1:0] load_mask, block_mask, new_hits, merged;
    logic [POP_W-1:0] merged_cnt;
    logic [CNT_W:0]   hit_sum, coal_sum;

    // Round-robin pick: rotate pending so ptr lands at bit 0, take the first set bit.
    always_comb begin
        rot   = WIDTH'({pending_q, pending_q} >> ptr_q);
        found = 1'b0;
        off   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = PTR_W'(i);
            end
        end
        sel_sum = {1'b0, ptr_q} + {1'b0, off};
        sel     = (sel_sum >= WIDTH_P) ? PTR_W'(sel_sum - WIDTH_P) : PTR_W'(sel_sum);
    end

    always_comb begin
        can_load   = !out_valid_q || bus.out_ready;
        do_load    = found && can_load;
        handshake  = out_valid_q && bus.out_ready;
        load_mask  = do_load ? (WIDTH'(1) << sel) : '0;
        accept     = bus.enable && (state_q == ST_RUN);
        block_mask = ONCE ? (reported_q | load_mask) : '0;
        new_hits   = bus.valid & {WIDTH{accept}} & ~block_mask;
        merged     = new_hits & pending_q & ~load_mask;
        merged_cnt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            merged_cnt = merged_cnt + POP_W'(merged[i]);
        end
        hit_sum  = {1'b0, hit_count_q} + (CNT_W + 1)'(handshake);
        coal_sum = {1'b0, coal_count_q} + (CNT_W + 1)'(merged_cnt);

        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        ptr_d       = ptr_q;
        if (do_load) begin
            out_valid_d = 1'b1;
            out_index_d = IDX_W'(COVER_INDEX) + IDX_W'(sel);
            ptr_d       = (sel == LAST) ? '0 : sel + PTR_W'(1);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // clear drops this cycle's hits but lets an in-flight report count from zero
        if (clear_i) begin
            pending_d    = '0;
            reported_d   = '0;
            hit_count_d  = CNT_W'(handshake);
            coal_count_d = '0;
        end else begin
            pending_d    = (pending_q & ~load_mask) | new_hits;
            reported_d   = reported_q | load_mask;
            hit_count_d  = hit_sum[CNT_W] ? '1 : hit_sum[CNT_W-1:0];
            coal_count_d = coal_sum[CNT_W] ? '1 : coal_sum[CNT_W-1:0];
        end

        state_d = state_q;
        case (state_q)
            ST_RUN:   if (flush_req_i) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!flush_req_i) begin
                    state_d = ST_RUN;
                end else if ((pending_q == '0) && !out_valid_d) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  if (!flush_req_i) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase

        flush_done_d = (state_d == ST_DONE);
        idle_d       = (pending_d == '0) && !out_valid_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_RUN;
            ptr_q        <= '0;
            pending_q    <= '0;
            reported_q   <= '0;
            out_valid_q  <= 1'b0;
            out_index_q  <= '0;
            hit_count_q  <= '0;
            coal_count_q <= '0;
            flush_done_q <= 1'b0;
            idle_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            pending_q    <= pending_d;
            reported_q   <= reported_d;
            out_valid_q  <= out_valid_d;
            out_index_q  <= out_index_d;
            hit_count_q  <= hit_count_d;
            coal_count_q <= coal_count_d;
            flush_done_q <= flush_done_d;
            idle_q       <= idle_d;
        end
    end

    // Group must fit inside the design's cover-point range.
    always_ff @(posedge clk_i) begin
        assert (64'(COVER_INDEX) + 64'(WIDTH) <= 64'(COVER_TOTAL))
            else $error("toggle_cover_scheduler: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_index    = out_index_q;
    assign flush_done_o     = flush_done_q;
    assign idle_o           = idle_q;
    assign hit_count_o      = hit_count_q;
    assign coalesce_count_o = coal_count_q;
endmodule

// File: tb/tb_toggle_cover_scheduler.sv
// Bench for toggle_cover_scheduler: a repeat-reporting and a report-once instance share
// one stimulus stream and are compared each cycle against a per-instance reference model.
module tb_toggle_cover_scheduler;
    localparam int unsigned WIDTH = 4;
    localparam int          W     = 4;
    localparam int          CIDX  = 100;
    localparam longint unsigned SAT = 64'hFFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, clear, flush_req, enable, out_ready;
    logic [WIDTH-1:0] valid;

    toggle_cover_scheduler_if #(.WIDTH(WIDTH)) if0 ();
    toggle_cover_scheduler_if #(.WIDTH(WIDTH)) if1 ();

    assign if0.valid     = valid;
    assign if0.enable    = enable;
    assign if0.out_ready = out_ready;
    assign if1.valid     = valid;
    assign if1.enable    = enable;
    assign if1.out_ready = out_ready;

    logic        ov_o [2];
    logic [63:0] oi_o [2];
    logic        fd   [2];
    logic        idl  [2];
    logic [31:0] hc   [2];
    logic [31:0] cc   [2];

    assign ov_o[0] = if0.out_valid;
    assign ov_o[1] = if1.out_valid;
    assign oi_o[0] = if0.out_index;
    assign oi_o[1] = if1.out_index;

    toggle_cover_scheduler #(
        .WIDTH(WIDTH), .COVER_TOTAL(8940), .COVER_INDEX(CIDX), .ONCE(1'b0)
    ) u_dut0 (
        .clk_i(clk), .rst_i(rst), .bus(if0.slave), .clear_i(clear),
        .flush_req_i(flush_req), .flush_done_o(fd[0]), .idle_o(idl[0]),
        .hit_count_o(hc[0]), .coalesce_count_o(cc[0])
    );

    toggle_cover_scheduler #(
        .WIDTH(WIDTH), .COVER_TOTAL(8940), .COVER_INDEX(CIDX), .ONCE(1'b1)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst), .bus(if1.slave), .clear_i(clear),
        .flush_req_i(flush_req), .flush_done_o(fd[1]), .idle_o(idl[1]),
        .hit_count_o(hc[1]), .coalesce_count_o(cc[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference model state; instance 0 repeats reports, instance 1 reports once.
    int              m_state [2];   // 0 RUN, 1 DRAIN, 2 DONE
    int              m_ptr   [2];
    bit              m_pend  [2][W];
    bit              m_rep   [2][W];
    bit              m_ov    [2];
    longint unsigned m_oi    [2];
    longint unsigned m_hc    [2];
    longint unsigned m_cc    [2];

    longint unsigned log0[$];
    longint unsigned log1[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_tick(input int m);
        bit once, can_load, hs, accept, pend_empty;
        bit nw[W];
        int sel, merged;
        once = (m == 1);
        if (rst) begin
            m_state[m] = 0; m_ptr[m] = 0; m_ov[m] = 0; m_oi[m] = 0;
            m_hc[m] = 0; m_cc[m] = 0;
            for (int b = 0; b < W; b++) begin
                m_pend[m][b] = 0;
                m_rep[m][b]  = 0;
            end
            return;
        end
        hs       = m_ov[m] && out_ready;
        can_load = !m_ov[m] || out_ready;
        sel      = -1;
        if (can_load) begin
            for (int k = 0; k < W; k++) begin
                if (sel < 0 && m_pend[m][(m_ptr[m] + k) % W]) sel = (m_ptr[m] + k) % W;
            end
        end
        accept     = enable && (m_state[m] == 0);
        pend_empty = 1;
        merged     = 0;
        for (int b = 0; b < W; b++) begin
            nw[b] = accept && valid[b] && !(once && (m_rep[m][b] || b == sel));
            if (nw[b] && m_pend[m][b] && b != sel) merged++;
            if (m_pend[m][b]) pend_empty = 0;
        end
        if (sel >= 0) begin
            m_ov[m]  = 1;
            m_oi[m]  = longint'(CIDX + sel);
            m_ptr[m] = (sel + 1) % W;
        end else if (out_ready) begin
            m_ov[m] = 0;
        end
        for (int b = 0; b < W; b++) begin
            m_pend[m][b] = !clear && ((m_pend[m][b] && b != sel) || nw[b]);
            m_rep[m][b]  = !clear && (m_rep[m][b] || b == sel);
        end
        if (clear) begin
            m_hc[m] = hs ? 1 : 0;
            m_cc[m] = 0;
        end else begin
            m_hc[m] = (m_hc[m] + hs > SAT) ? SAT : m_hc[m] + hs;
            m_cc[m] = (m_cc[m] + merged > SAT) ? SAT : m_cc[m] + merged;
        end
        case (m_state[m])
            0: if (flush_req) m_state[m] = 1;
            1: if (!flush_req) m_state[m] = 0;
               else if (pend_empty && !m_ov[m]) m_state[m] = 2;
            default: if (!flush_req) m_state[m] = 0;
        endcase
    endtask

    task automatic check_outputs();
        bit exp_idle;
        for (int m = 0; m < 2; m++) begin
            exp_idle = !m_ov[m];
            for (int b = 0; b < W; b++) if (m_pend[m][b]) exp_idle = 0;
            chk($sformatf("out_valid[%0d]", m), ov_o[m], m_ov[m]);
            chk($sformatf("out_index[%0d]", m), oi_o[m], m_oi[m]);
            chk($sformatf("idle[%0d]", m), idl[m], exp_idle);
            chk($sformatf("flush_done[%0d]", m), fd[m], m_state[m] == 2);
            chk($sformatf("hit_count[%0d]", m), hc[m], m_hc[m]);
            chk($sformatf("coalesce_count[%0d]", m), cc[m], m_cc[m]);
        end
    endtask

    // One clock: log handshakes seen on the DUT ports, advance the model, compare.
    task automatic step();
        @(negedge clk);
        if (!rst) begin
            if (ov_o[0] && out_ready) log0.push_back(oi_o[0]);
            if (ov_o[1] && out_ready) log1.push_back(oi_o[1]);
        end
        @(posedge clk);
        model_tick(0);
        model_tick(1);
        #1;
        check_outputs();
    endtask

    function automatic longint unsigned sig(input int m);
        longint unsigned s = 0;
        if (m == 0) foreach (log0[i]) s = s * 1000 + log0[i];
        else        foreach (log1[i]) s = s * 1000 + log1[i];
        return s;
    endfunction

    task automatic clear_pulse();
        clear = 1'b1;
        step();
        clear = 1'b0;
        log0.delete();
        log1.delete();
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; flush_req = 1'b0; enable = 1'b1;
        out_ready = 1'b1; valid = '0;
        step(); step();
        rst = 1'b0;
        chk("reset_ov", ov_o[0], 0);
        chk("reset_idle", idl[1], 1);
        chk("reset_hc", hc[0], 0);
        chk("reset_index", oi_o[1], 0);

        // Basic drain with two-cycle latency
        valid = 4'b1011;
        step();
        valid = '0;
        chk("t1_lat_ov_early", ov_o[0], 0);
        step();
        chk("t1_lat_ov", ov_o[0], 1);
        chk("t1_lat_idx", oi_o[0], 100);
        repeat (5) step();
        chk("t1_order0", sig(0), 64'd100101103);
        chk("t1_order1", sig(1), 64'd100101103);
        chk("t1_hc0", hc[0], 3);
        chk("t1_idle0", idl[0], 1);

        // Round-robin fairness
        clear_pulse();
        valid = 4'b0001; step(); valid = '0; repeat (4) step();
        valid = 4'b0001; step(); valid = '0; repeat (4) step();
        valid = 4'b1111; step(); valid = '0; repeat (6) step();
        chk("t2_order0", sig(0), 64'd100100101102103100);
        chk("t2_order1", sig(1), 64'd100101102103);
        chk("t2_hc0", hc[0], 6);
        chk("t2_hc1", hc[1], 4);

        // Report-once versus repeat reporting
        clear_pulse();
        repeat (5) begin
            valid = 4'b0100; step(); valid = '0; repeat (3) step();
        end
        chk("t3_reports0", sig(0), 64'd102102102102102);
        chk("t3_reports1", sig(1), 64'd102);
        chk("t3_hc1", hc[1], 1);
        clear_pulse();
        valid = 4'b0100; step(); valid = '0; repeat (4) step();
        chk("t3_rearm1", sig(1), 64'd102);
        chk("t3_rearm_hc1", hc[1], 1);

        // Backpressure and coalescing
        clear_pulse();
        out_ready = 1'b0; valid = 4'b0010;
        repeat (10) step();
        chk("t4_hold_idx0", oi_o[0], 101);
        chk("t4_hold_idx1", oi_o[1], 101);
        chk("t4_hold_hc0", hc[0], 0);
        chk("t4_coal0", cc[0], 8);
        chk("t4_coal1", cc[1], 0);
        valid = '0; out_ready = 1'b1;
        repeat (5) step();
        chk("t4_release0", sig(0), 64'd101101);
        chk("t4_release1", sig(1), 64'd101);

        // Flush drain, hold in DONE, resume
        clear_pulse();
        valid = 4'b1111; flush_req = 1'b1;
        repeat (6) step();
        chk("t5_done0", fd[0], 1);
        chk("t5_done1", fd[1], 1);
        chk("t5_drain0", sig(0), 64'd102103100101);
        chk("t5_drain1", sig(1), 64'd102103100101);
        repeat (5) step();
        chk("t5_quiet0", longint'(log0.size()), 4);
        chk("t5_still_done1", fd[1], 1);
        flush_req = 1'b0;
        repeat (6) step();
        chk("t5_resume0", longint'(log0.size() > 4), 1);
        chk("t5_noresume1", longint'(log1.size()), 4);
        valid = '0;
        repeat (8) step();

        // Reset with a report in flight and bits pending
        clear_pulse();
        out_ready = 1'b0; valid = 4'b1111;
        step();
        valid = '0;
        step();
        chk("t6_inflight0", ov_o[0], 1);
        chk("t6_inflight1", ov_o[1], 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_ov0", ov_o[0], 0);
        chk("t6_idle1", idl[1], 1);
        chk("t6_index0", oi_o[0], 0);
        log0.delete(); log1.delete();
        out_ready = 1'b1;
        repeat (4) step();
        chk("t6_nostale0", longint'(log0.size()), 0);
        chk("t6_nostale1", longint'(log1.size()), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            valid     = WIDTH'($urandom);
            enable    = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 29) == 0) flush_req = !flush_req;
            step();
        end
        rst = 1'b0; clear = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
